// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the decode-side hazard scoreboard.
// Entry fields are sized for the largest supported configuration.
package hazard_scoreboard_pkg;

  localparam int RD_MAX = 8;
  localparam int AV_MAX = 4;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              v;
    logic [RD_MAX-1:0] rd;
    logic [AV_MAX-1:0] avail;
  } sb_entry_t;

  function automatic int w1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Priority search of one source operand over the in-flight writers.
// The youngest matching stage decides between forward and stall.
module sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int NSTAGE = 2,
  parameter int REG_W  = 5,
  parameter int SEL_W  = 2
) (
  input  sb_entry_t [NSTAGE-1:0] ents,
  input  logic [REG_W-1:0]       ra,
  output logic                   hit,
  output logic [SEL_W-1:0]       sel,
  output logic                   stall
);

  // Walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    hit   = 1'b0;
    sel   = SEL_W'(FWD_RF);
    stall = 1'b0;
    for (int s = NSTAGE - 1; s >= 0; s--) begin
      if (ra != '0 && ents[s].v &&
          ents[s].rd == RD_MAX'(ra)) begin
        hit = 1'b1;
        if (AV_MAX'(s) >= ents[s].avail) begin
          sel   = SEL_W'(s + 1);
          stall = 1'b0;
        end else begin
          sel   = SEL_W'(FWD_RF);
          stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side scoreboard: in-flight writer shift register,
// forwarding selects, load-use and HI/LO stalls.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NSTAGE = 2,
  parameter int NSRC   = 2,
  parameter int LAT_W  = 6,
  parameter int REG_W  = 5,
  localparam int AW    = w1(NSTAGE),
  localparam int SW    = $clog2(NSTAGE + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  adv,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [REG_W-1:0]      issue_rd,
  input  logic [AW-1:0]         issue_avail,
  input  logic                  issue_hilo,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic [NSRC*REG_W-1:0] src_ra,
  input  logic                  src_hilo,
  output logic [NSRC*SW-1:0]    fwd_sel,
  output logic                  stall,
  output logic                  hilo_busy
);

  sb_entry_t [NSTAGE-1:0] ents;
  logic [LAT_W-1:0]       hilo_cnt;
  logic [NSRC-1:0]        src_stall;
  logic                   hilo_load;
  sb_entry_t              ins;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic          hit;
    logic [SW-1:0] sel;
    sb_match #(
      .NSTAGE(NSTAGE),
      .REG_W (REG_W),
      .SEL_W (SW)
    ) u_match (
      .ents (ents),
      .ra   (src_ra[i*REG_W +: REG_W]),
      .hit  (hit),
      .sel  (sel),
      .stall(src_stall[i])
    );
    assign fwd_sel[i*SW +: SW] = hit ? sel : SW'(FWD_RF);
  end

  assign hilo_busy = (hilo_cnt != '0);

  // Single divider: a new HI/LO op also waits for the busy one.
  assign stall = (|src_stall) ||
                 (hilo_busy && (src_hilo || issue_hilo));

  assign ins.v     = issue_valid && (issue_rd != '0) && !stall;
  assign ins.rd    = RD_MAX'(issue_rd);
  assign ins.avail = AV_MAX'(issue_avail);

  assign hilo_load = issue_hilo && issue_valid && adv &&
                     !stall && !flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ents <= '0;
    end else if (flush) begin
      ents <= '0;
    end else if (adv) begin
      for (int s = NSTAGE - 1; s > 0; s--) begin
        ents[s] <= ents[s-1];
      end
      ents[0] <= ins;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hilo_cnt <= '0;
    end else if (hilo_load) begin
      hilo_cnt <= issue_lat;
    end else if (hilo_busy) begin
      hilo_cnt <= hilo_cnt - 1'b1;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the decode-stage forwarding/stall logic. It tracks in-flight register writers across a configurable number of post-decode stages (NSTAGE), resolves forwarding selects for NSRC source operands, and raises load-use and multi-cycle HI/LO stalls. It sits beside decode: decode queries it every cycle and pushes each issued instruction's destination into it.

Parameters:
NSTAGE, 2, post-decode stages tracked (index 0 = execute, NSTAGE-1 = oldest)
NSRC, 2, number of source-operand query ports
LAT_W, 6, width of the multi-cycle HI/LO latency counter
REG_W, 5, register address width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
adv  in  1  pipeline advances this cycle (entries shift one stage)
flush  in  1  kill all tracked entries and any same-cycle issue
issue_valid  in  1  decode issues an instruction (honoured only when adv=1)
issue_rd  in  REG_W  destination register; 0 means none
issue_avail  in  $clog2(NSTAGE)  first stage index where the result is forwardable (0 = ALU, 1 = load)
issue_hilo  in  1  instruction starts a multi-cycle HI/LO write
issue_lat  in  LAT_W  cycles until HI/LO result is valid (issue_hilo only)
src_ra  in  NSRC*REG_W  queried source registers
src_hilo  in  1  decoded instruction reads HI/LO
fwd_sel  out  NSRC*$clog2(NSTAGE+1)  per source: 0 = regfile, k = forward from stage k-1
stall  out  1  decode must hold
hilo_busy  out  1  HI/LO counter nonzero

Behaviour:
- State: NSTAGE entries {v, rd, avail}, plus hilo_cnt[LAT_W]. Reset: all v=0, hilo_cnt=0, so fwd_sel=0, stall=0, hilo_busy=0.
- Shift, when adv=1 and flush=0: entry[s+1] <= entry[s]; the oldest entry drops out. entry[0] <= {issue_valid && issue_rd!=0 && !stall, issue_rd, issue_avail}. An issue with stall=1 inserts a bubble.
- adv=0: entries hold; issue_valid is ignored.
- flush=1: all v <= 0 next cycle, regardless of adv or issue. hilo_cnt is not cleared.
- hilo_cnt: if issue_hilo && issue_valid && adv && !stall && !flush, load issue_lat. Otherwise decrement if nonzero, every cycle, independent of adv. Saturates at 0. hilo_busy = (hilo_cnt!=0).
- Query (combinational from state and inputs, no latency):
  - For each source i with src_ra[i]!=0, find the lowest s with v && rd==src_ra[i]; the youngest match wins.
  - If s>=avail: fwd_sel[i]=s+1. Else fwd_sel[i]=0 and the source stalls.
  - No match, or src_ra[i]==0: fwd_sel[i]=0, no stall.
- stall = OR of source stalls, OR (src_hilo && hilo_busy), OR (issue_hilo && hilo_busy) (structural: a single divider).
- Boundary cases:
  - issue_lat=0 behaves as no busy.
  - A writer that has shifted out of the last stage is no longer tracked; the regfile holds the value (write-before-read regfile required).
  - Reset asserted mid-operation clears everything asynchronously.
  - The same register in multiple entries resolves to the youngest entry.
  - Both sources matching the same entry each get the same fwd_sel.

Decomposition:
- Package (pipeline package): sb_entry_t struct {v, rd, avail}; FWD_RF=0 constant; parameter-derived width localparams.
- One sub-module, sb_match: per-source priority search over the entry array, producing {hit, sel, stall}, instantiated NSRC times.
- Top-level holds the shift register and hilo counter.

Test Plan:
- ALU RAW: issue rd=5 avail=0 with adv, next cycle src_ra[0]=5 -> fwd_sel[0]=1, stall=0. After one more adv -> fwd_sel[0]=2. After one more (NSTAGE=2) -> fwd_sel[0]=0.
- Load-use: issue rd=8 avail=1, query src_ra[1]=8 -> stall=1. Then adv=1 with issue_valid=1 -> bubble inserted, next cycle fwd_sel[1]=2, stall=0.
- Youngest priority: issue rd=3 twice on consecutive adv cycles, query 3 -> fwd_sel=1 (not 2). Query reg 0 with an rd=0 issue -> fwd_sel=0, stall=0.
- HI/LO: issue_hilo lat=10 -> hilo_busy=1 for exactly 10 cycles. src_hilo=1 during that window -> stall=1, and stall=1 also while adv=0. A second issue_hilo during busy -> stall=1.
- Flush: entries at rd=4,7 with flush=1 and issue rd=9 -> next cycle all queries fwd_sel=0, stall=0; hilo_cnt keeps counting.
- Async reset: assert resetn=0 mid-stall with hilo_cnt=5 -> stall, hilo_busy and fwd_sel go to 0 immediately, without a clock edge.
